// File: rtl/morse_uart_tx.sv
// Morse decoder to UART bridge: translates decoder character codes to ASCII,
// queues them in a small FIFO and transmits each as an 8N1 frame.
module morse_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        cclk,
  input  logic        rstb,
  input  logic        send_ena,
  input  logic [40:0] send_byte,
  output logic        done_reading,
  output logic        tx,
  output logic        busy,
  output logic [4:0]  fifo_count
);

  localparam int          PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [4:0]  DEPTH_C  = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  tx_state_t        state, state_nxt;
  logic [15:0]      baud_cnt, baud_nxt;
  logic [2:0]       bit_idx, idx_nxt;
  logic [7:0]       shreg;
  logic             tx_nxt, busy_nxt;
  logic             bit_end;

  logic             armed;
  logic             capture;
  logic             pop;
  logic [7:0]       ascii;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [7:0]       fifo_mem [FIFO_DEPTH];

  // Any nonzero upper bit makes the code invalid regardless of the low bits.
  always_comb begin
    ascii = 8'h3F;
    if (send_byte[40:6] == '0) begin
      if (send_byte[5:0] >= 6'd1 && send_byte[5:0] <= 6'd26)
        ascii = 8'h40 + {2'b00, send_byte[5:0]};
      else if (send_byte[5:0] == 6'd27)
        ascii = 8'h20;
      else if (send_byte[5:0] >= 6'd28 && send_byte[5:0] <= 6'd36)
        ascii = {2'b00, send_byte[5:0]} + 8'h15;
      else if (send_byte[5:0] == 6'd37)
        ascii = 8'h2B;
      else if (send_byte[5:0] == 6'd38)
        ascii = 8'h3D;
      else if (send_byte[5:0] == 6'd39)
        ascii = 8'h2F;
    end
  end

  assign capture = send_ena && armed && (fifo_count < DEPTH_C);

  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      armed        <= 1'b1;
      done_reading <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
    end else begin
      done_reading <= capture;
      if (capture)
        armed <= 1'b0;
      else if (!send_ena)
        armed <= 1'b1;
      if (capture)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({capture, pop})
        2'b10:   fifo_count <= fifo_count + 5'd1;
        2'b01:   fifo_count <= fifo_count - 5'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge cclk) begin
    if (capture)
      fifo_mem[wr_ptr] <= ascii;
  end

  assign bit_end = (baud_cnt == BIT_LAST);

  // tx and busy are registered from the current state, so the line trails the
  // FSM by one cycle; every bit still lasts exactly CLKS_PER_BIT cycles.
  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= idx_nxt;
      tx       <= tx_nxt;
      busy     <= busy_nxt;
      if (pop)
        shreg <= fifo_mem[rd_ptr];
    end
  end

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt + 16'd1;
    idx_nxt   = bit_idx;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        baud_nxt = '0;
        if (fifo_count != '0) begin
          pop       = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_nxt  = '0;
          idx_nxt   = '0;
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_nxt = '0;
          idx_nxt  = bit_idx + 3'd1;
          if (bit_idx == 3'd7)
            state_nxt = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_nxt  = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        baud_nxt  = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    tx_nxt   = 1'b1;
    busy_nxt = 1'b0;
    case (state)
      START: begin
        tx_nxt   = 1'b0;
        busy_nxt = 1'b1;
      end
      DATA: begin
        tx_nxt   = shreg[bit_idx];
        busy_nxt = 1'b1;
      end
      STOP: begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b1;
      end
      default: begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_morse_uart_tx.sv
// Bench for morse_uart_tx: random character codes, a UART line receiver and
// an arithmetic translation model.
module tb_morse_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic        cclk = 1'b0;
  logic        rstb = 1'b0;
  logic        send_ena = 1'b0;
  logic [40:0] send_byte = '0;
  logic        done_reading;
  logic        tx;
  logic        busy;
  logic [4:0]  fifo_count;

  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;

  morse_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .cclk(cclk), .rstb(rstb), .send_ena(send_ena), .send_byte(send_byte),
    .done_reading(done_reading), .tx(tx), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 cclk = ~cclk;
  always @(posedge cclk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  data;
    bit          shape_ok;
    int unsigned start;
  } frame_t;

  frame_t      frames[$];
  frame_t      mon_f;
  logic        mon_s [FRAME];
  bit          mon_busy = 0;
  int unsigned mon_n = 0;
  int unsigned mon_start = 0;
  int unsigned dr_pulses = 0;
  bit          dr_double = 0;
  logic        dr_prev = 1'b0;
  int unsigned max_cnt = 0;

  // Line receiver: one sample per cycle, every sample of a bit must agree.
  always @(negedge cclk) begin
    if (!rstb) begin
      mon_busy = 0;
      dr_prev  = 1'b0;
    end else begin
      if (done_reading === 1'b1) begin
        if (dr_prev === 1'b1) dr_double = 1;
        else dr_pulses++;
      end
      dr_prev = done_reading;
      if (fifo_count > max_cnt) max_cnt = fifo_count;
      if (!mon_busy) begin
        if (tx === 1'b0) begin
          mon_busy  = 1;
          mon_start = cyc;
          mon_s[0]  = 1'b0;
          mon_n     = 1;
        end
      end else begin
        mon_s[mon_n] = tx;
        mon_n++;
        if (mon_n == FRAME) begin
          mon_f.shape_ok = 1;
          mon_f.start    = mon_start;
          mon_f.data     = '0;
          for (int b = 0; b < 10; b++)
            for (int k = 1; k < CPB; k++)
              if (mon_s[b*CPB+k] !== mon_s[b*CPB]) mon_f.shape_ok = 0;
          if (mon_s[9*CPB] !== 1'b1) mon_f.shape_ok = 0;
          for (int b = 0; b < 8; b++) mon_f.data[b] = mon_s[(b+1)*CPB];
          frames.push_back(mon_f);
          mon_busy = 0;
        end
      end
    end
  end

  function automatic logic [7:0] ref_ascii(input logic [40:0] c);
    if (c >= 41'd1 && c <= 41'd26) return 8'(c + 41'd64);
    if (c == 41'd27) return 8'h20;
    if (c >= 41'd28 && c <= 41'd36) return 8'(c - 41'd28 + 41'd49);
    if (c == 41'd37) return 8'h2B;
    if (c == 41'd38) return 8'h3D;
    if (c == 41'd39) return 8'h2F;
    return 8'h3F;
  endfunction

  function automatic logic [40:0] rand_code();
    logic [40:0] c;
    int sel = int'($urandom_range(0, 3));
    int hb  = int'($urandom_range(6, 40));
    if (sel < 2) c = 41'($urandom_range(1, 39));
    else if (sel == 2) c = 41'($urandom_range(0, 63));
    else begin
      c = {9'($urandom), 32'($urandom)};
      c[hb] = 1'b1;
    end
    return c;
  endfunction

  task automatic tick();
    @(negedge cclk);
    #1;
  endtask

  task automatic send_char(input logic [40:0] code, input int unsigned budget,
                           output bit ok, output int unsigned cap_cyc,
                           output int unsigned waited, output logic [4:0] prev_cnt);
    send_byte = code;
    send_ena  = 1'b1;
    ok        = 0;
    cap_cyc   = 0;
    waited    = 0;
    prev_cnt  = fifo_count;
    while (!ok && waited < budget) begin
      tick();
      waited++;
      if (done_reading === 1'b1) begin
        ok      = 1;
        cap_cyc = cyc;
      end else begin
        prev_cnt = fifo_count;
      end
    end
    send_ena = 1'b0;
    tick();
  endtask

  task automatic wait_frames(input int n, input int unsigned budget, output bit ok);
    int unsigned t = 0;
    while (frames.size() < n && t < budget) begin
      tick();
      t++;
    end
    ok = (frames.size() >= n);
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    send_ena = 1'b0;
    repeat (3) tick();
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done_reading !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done_reading); end
    n_checks++; if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    rstb = 1'b1;
  endtask

  task automatic test_single();
    bit ok;
    int unsigned cap, w, r, d0;
    logic [4:0] pc;
    r  = cyc;
    d0 = dr_pulses;
    frames.delete();
    send_char(41'd1, 20, ok, cap, w, pc);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_capture: got %b expected 1", ok); end
    n_checks++; if (cap != r + 1) begin n_fail++; $display("FAIL first_edge_capture: got cycle %0d expected %0d", cap, r + 1); end
    tick();
    n_checks++; if (tx !== 1'b0) begin n_fail++; $display("FAIL start_tx: got %b expected 0", tx); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL start_busy: got %b expected 1", busy); end
    wait_frames(1, 200, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_frame_timeout: got %0d frames expected 1", frames.size()); end
    if (frames.size() > 0) begin
      n_checks++; if (frames[0].data !== ref_ascii(41'd1)) begin n_fail++; $display("FAIL single_data: got %h expected %h", frames[0].data, ref_ascii(41'd1)); end
      n_checks++; if (frames[0].shape_ok !== 1'b1) begin n_fail++; $display("FAIL single_shape: got %b expected 1", frames[0].shape_ok); end
      n_checks++; if (frames[0].start - cap != 2) begin n_fail++; $display("FAIL start_latency: got %0d expected 2", frames[0].start - cap); end
    end
    repeat (2) tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy); end
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL idle_tx: got %b expected 1", tx); end
    n_checks++; if (dr_pulses - d0 != 1) begin n_fail++; $display("FAIL single_done_pulses: got %0d expected 1", dr_pulses - d0); end
  endtask

  task automatic test_translate();
    logic [40:0] codes[$];
    logic [7:0]  exp_q[$];
    bit ok;
    int unsigned cap, w;
    logic [4:0] pc;
    codes = '{41'd27, 41'd36, 41'd37, 41'd39, 41'd0, 41'h100_0000_0000};
    repeat (8) codes.push_back(rand_code());
    frames.delete();
    foreach (codes[i]) begin
      exp_q.push_back(ref_ascii(codes[i]));
      send_char(codes[i], 400, ok, cap, w, pc);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL translate_capture[%0d]: got %b expected 1", i, ok); end
    end
    wait_frames(codes.size(), 2000, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL translate_frames: got %0d expected %0d", frames.size(), codes.size()); end
    foreach (exp_q[i]) begin
      if (i < frames.size()) begin
        n_checks++; if (frames[i].data !== exp_q[i]) begin n_fail++; $display("FAIL translate_data[%0d] code %h: got %h expected %h", i, codes[i], frames[i].data, exp_q[i]); end
        n_checks++; if (frames[i].shape_ok !== 1'b1) begin n_fail++; $display("FAIL translate_shape[%0d]: got %b expected 1", i, frames[i].shape_ok); end
      end
    end
  endtask

  task automatic test_hold();
    logic [40:0] code;
    bit ok;
    int unsigned d0;
    code = rand_code();
    frames.delete();
    d0 = dr_pulses;
    send_byte = code;
    send_ena  = 1'b1;
    repeat (20) tick();
    send_ena = 1'b0;
    tick();
    n_checks++; if (dr_pulses - d0 != 1) begin n_fail++; $display("FAIL hold_done_pulses: got %0d expected 1", dr_pulses - d0); end
    n_checks++; if (dr_double !== 1'b0) begin n_fail++; $display("FAIL done_double: got %b expected 0", dr_double); end
    wait_frames(1, 200, ok);
    repeat (2 * FRAME) tick();
    n_checks++; if (frames.size() != 1) begin n_fail++; $display("FAIL hold_frames: got %0d expected 1", frames.size()); end
    if (frames.size() > 0) begin
      n_checks++; if (frames[0].data !== ref_ascii(code)) begin n_fail++; $display("FAIL hold_data: got %h expected %h", frames[0].data, ref_ascii(code)); end
    end
  endtask

  task automatic test_back_to_back();
    logic [40:0] code;
    logic [7:0]  exp_q[$];
    int unsigned waits[6];
    bit ok;
    int unsigned cap;
    logic [4:0] pc;
    frames.delete();
    max_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      code = rand_code();
      exp_q.push_back(ref_ascii(code));
      send_char(code, 200, ok, cap, waits[i], pc);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL b2b_capture[%0d]: got %b expected 1", i, ok); end
      n_checks++; if (pc >= DEPTH) begin n_fail++; $display("FAIL capture_when_full[%0d]: count before capture %0d expected < %0d", i, pc, DEPTH); end
    end
    n_checks++; if (max_cnt != DEPTH) begin n_fail++; $display("FAIL b2b_max_count: got %0d expected %0d", max_cnt, DEPTH); end
    n_checks++; if (waits[5] <= 2 * CPB) begin n_fail++; $display("FAIL b2b_held_off: waited %0d cycles expected > %0d", waits[5], 2 * CPB); end
    wait_frames(6, 6 * FRAME + 200, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL b2b_frames: got %0d expected 6", frames.size()); end
    foreach (exp_q[i]) begin
      if (i < frames.size()) begin
        n_checks++; if (frames[i].data !== exp_q[i]) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, frames[i].data, exp_q[i]); end
        if (i > 0) begin
          n_checks++; if (frames[i].start - frames[i-1].start != FRAME + 1) begin n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", i, frames[i].start - frames[i-1].start, FRAME + 1); end
        end
      end
    end
  endtask

  task automatic test_simul();
    logic [40:0] codes[4];
    bit ok;
    int unsigned cap, w, s, t;
    logic [4:0] pc;
    foreach (codes[i]) codes[i] = rand_code();
    frames.delete();
    for (int i = 0; i < 3; i++) begin
      send_char(codes[i], 200, ok, cap, w, pc);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL simul_capture[%0d]: got %b expected 1", i, ok); end
    end
    t = 0;
    while (!mon_busy && t < 100) begin tick(); t++; end
    s = mon_start;
    t = 0;
    while (cyc < s + FRAME - 1 && t < 200) begin tick(); t++; end
    n_checks++; if (cyc != s + FRAME - 1) begin n_fail++; $display("FAIL simul_align: got cycle %0d expected %0d", cyc, s + FRAME - 1); end
    n_checks++; if (fifo_count !== 5'd2) begin n_fail++; $display("FAIL simul_pre_count: got %0d expected 2", fifo_count); end
    send_byte = codes[3];
    send_ena  = 1'b1;
    tick();
    n_checks++; if (done_reading !== 1'b1) begin n_fail++; $display("FAIL simul_done: got %b expected 1", done_reading); end
    n_checks++; if (fifo_count !== 5'd2) begin n_fail++; $display("FAIL simul_count: got %0d expected 2", fifo_count); end
    send_ena = 1'b0;
    tick();
    wait_frames(4, 4 * FRAME + 200, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL simul_frames: got %0d expected 4", frames.size()); end
    foreach (codes[i]) begin
      if (i < frames.size()) begin
        n_checks++; if (frames[i].data !== ref_ascii(codes[i])) begin n_fail++; $display("FAIL simul_data[%0d]: got %h expected %h", i, frames[i].data, ref_ascii(codes[i])); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [40:0] code;
    bit ok;
    int unsigned cap, w, s, t, lows;
    logic [4:0] pc;
    frames.delete();
    send_char(41'd1, 200, ok, cap, w, pc);
    send_char(rand_code(), 200, ok, cap, w, pc);
    send_char(rand_code(), 200, ok, cap, w, pc);
    t = 0;
    while (!mon_busy && t < 100) begin tick(); t++; end
    s = mon_start;
    t = 0;
    while (cyc < s + 4 * CPB + 1 && t < 200) begin tick(); t++; end
    n_checks++; if (tx !== 1'b0) begin n_fail++; $display("FAIL mid_bit3_tx: got %b expected 0", tx); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b expected 1", busy); end
    n_checks++; if (fifo_count !== 5'd2) begin n_fail++; $display("FAIL mid_count: got %0d expected 2", fifo_count); end
    rstb = 1'b0;
    #1;
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL abort_tx: got %b expected 1", tx); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
    n_checks++; if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL abort_count: got %0d expected 0", fifo_count); end
    n_checks++; if (done_reading !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b expected 0", done_reading); end
    tick();
    tick();
    rstb = 1'b1;
    lows = 0;
    repeat (3 * FRAME) begin
      tick();
      if (tx !== 1'b1) lows++;
    end
    n_checks++; if (lows != 0) begin n_fail++; $display("FAIL post_reset_tx_low: got %0d low cycles expected 0", lows); end
    n_checks++; if (frames.size() != 0) begin n_fail++; $display("FAIL post_reset_frames: got %0d expected 0", frames.size()); end
    code = rand_code();
    send_char(code, 50, ok, cap, w, pc);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL post_reset_capture: got %b expected 1", ok); end
    wait_frames(1, 200, ok);
    if (frames.size() > 0) begin
      n_checks++; if (frames[0].data !== ref_ascii(code)) begin n_fail++; $display("FAIL post_reset_data: got %h expected %h", frames[0].data, ref_ascii(code)); end
    end else begin
      n_checks++; n_fail++; $display("FAIL post_reset_frame: got 0 frames expected 1");
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_translate();
    test_hold();
    test_back_to_back();
    test_simul();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
